// File: rtl/crf_multi_ch_if.sv
// rtl/crf_multi_ch_if.sv - AXI4-Lite slave port bundle for the multi-channel config register file
interface crf_multi_ch_if #(
   parameter int ADDR_WIDTH = 12
);
   logic                  s_axi_awvalid;
   logic                  s_axi_awready;
   logic [ADDR_WIDTH-1:0] s_axi_awaddr;
   logic [2:0]            s_axi_awprot;
   logic                  s_axi_wvalid;
   logic                  s_axi_wready;
   logic [31:0]           s_axi_wdata;
   logic [3:0]            s_axi_wstrb;
   logic                  s_axi_bvalid;
   logic                  s_axi_bready;
   logic [1:0]            s_axi_bresp;
   logic                  s_axi_arvalid;
   logic                  s_axi_arready;
   logic [ADDR_WIDTH-1:0] s_axi_araddr;
   logic [2:0]            s_axi_arprot;
   logic                  s_axi_rvalid;
   logic                  s_axi_rready;
   logic [31:0]           s_axi_rdata;
   logic [1:0]            s_axi_rresp;

   modport slave (
      input  s_axi_awvalid, s_axi_awaddr, s_axi_awprot, s_axi_wvalid, s_axi_wdata, s_axi_wstrb,
             s_axi_bready, s_axi_arvalid, s_axi_araddr, s_axi_arprot, s_axi_rready,
      output s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_arready,
             s_axi_rvalid, s_axi_rdata, s_axi_rresp
   );

   modport master (
      output s_axi_awvalid, s_axi_awaddr, s_axi_awprot, s_axi_wvalid, s_axi_wdata, s_axi_wstrb,
             s_axi_bready, s_axi_arvalid, s_axi_araddr, s_axi_arprot, s_axi_rready,
      input  s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_arready,
             s_axi_rvalid, s_axi_rdata, s_axi_rresp
   );
endinterface

// File: rtl/crf_multi_ch.sv
// rtl/crf_multi_ch.sv - AXI4-Lite config register file for N_CH upsampler channels
module crf_multi_ch #(
   parameter int N_CH           = 4,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ADDR_WIDTH = 12,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   crf_multi_ch_if.slave       axi,
   output logic [N_CH-1:0]     crf_ac_upstart,
   output logic [N_CH-1:0]     crf_ac_busy,
   input  logic [N_CH-1:0]     ac_crf_done,
   output logic                interrupt_updone
);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic                      aw_held, w_held, bvalid, rvalid;
   logic [AXI_ADDR_WIDTH-1:0] awaddr_q;
   logic [31:0]               wdata_q;
   logic [3:0]                wstrb_q;
   logic [1:0]                bresp, rresp;
   logic [AXI_DATA_WIDTH-1:0] rdata;

   logic [N_CH-1:0]           irq_en, busy, done_flag, upstart;
   logic [CNT_WIDTH-1:0]      cnt [N_CH];

   // Channel windows occupy 0x000-0x0FF; IRQSTAT is the single word at 0x100.
   function automatic void decode(input logic [AXI_ADDR_WIDTH-1:0] a, output logic ok,
                                  output logic is_irq, output logic [3:0] ch, output logic [1:0] off);
      ok     = 1'b0;
      is_irq = 1'b0;
      ch     = a[7:4];
      off    = a[3:2];
      if (a[AXI_ADDR_WIDTH-1:8] == '0) begin
         ok = (int'(a[7:4]) < N_CH);
      end else if (a[AXI_ADDR_WIDTH-1:8] == (AXI_ADDR_WIDTH-8)'(1) && a[7:2] == 6'd0) begin
         ok     = 1'b1;
         is_irq = 1'b1;
      end
   endfunction

   logic       wr_ok, wr_irq, rd_ok, rd_irq;
   logic [3:0] wr_ch, rd_ch;
   logic [1:0] wr_off, rd_off;
   logic       wr_fire, ctrl_en, stat_en;
   logic [N_CH-1:0] start_req, w1c, irq_en_nxt, done_ev, start_ok;
   logic [AXI_DATA_WIDTH-1:0] rd_word;

   always_comb begin
      decode(awaddr_q, wr_ok, wr_irq, wr_ch, wr_off);
      decode(axi.s_axi_araddr, rd_ok, rd_irq, rd_ch, rd_off);
   end

   assign wr_fire = aw_held && w_held && !bvalid;
   assign ctrl_en = wr_fire && wr_ok && !wr_irq && wr_off == 2'd0 && wstrb_q[0];
   assign stat_en = wr_fire && wr_ok && !wr_irq && wr_off == 2'd1 && wstrb_q[0];

   always_comb begin
      start_req  = '0;
      w1c        = '0;
      irq_en_nxt = irq_en;
      for (int i = 0; i < N_CH; i++) begin
         if (wr_ch == 4'(i)) begin
            if (ctrl_en) begin
               start_req[i]  = wdata_q[0];
               irq_en_nxt[i] = wdata_q[1];
            end
            if (stat_en) w1c[i] = wdata_q[1];
         end
      end
   end

   // Both START and done are judged against the pre-update BUSY, so a coincident done wins.
   assign done_ev  = ac_crf_done & busy;
   assign start_ok = start_req & ~busy;

   always_comb begin
      rd_word = '0;
      if (rd_ok && rd_irq) begin
         rd_word[N_CH-1:0] = done_flag & irq_en;
      end else if (rd_ok) begin
         for (int i = 0; i < N_CH; i++) begin
            if (rd_ch == 4'(i)) begin
               case (rd_off)
                  2'd0:    rd_word[1]           = irq_en[i];
                  2'd1:    rd_word[1:0]         = {done_flag[i], busy[i]};
                  2'd2:    rd_word[CNT_WIDTH-1:0] = cnt[i];
                  default: rd_word              = '0;
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         irq_en           <= '0;
         busy             <= '0;
         done_flag        <= '0;
         upstart          <= '0;
         interrupt_updone <= 1'b0;
         for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
      end else begin
         irq_en           <= irq_en_nxt;
         upstart          <= start_ok;
         busy             <= (busy & ~done_ev) | start_ok;
         done_flag        <= done_ev | (done_flag & ~w1c);
         interrupt_updone <= |(done_flag & irq_en);
         for (int i = 0; i < N_CH; i++) begin
            if (done_ev[i]) cnt[i] <= cnt[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         aw_held  <= 1'b0;
         w_held   <= 1'b0;
         awaddr_q <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         bvalid   <= 1'b0;
         bresp    <= RESP_OKAY;
      end else begin
         if (axi.s_axi_awvalid && axi.s_axi_awready) begin
            aw_held  <= 1'b1;
            awaddr_q <= axi.s_axi_awaddr;
         end
         if (axi.s_axi_wvalid && axi.s_axi_wready) begin
            w_held  <= 1'b1;
            wdata_q <= axi.s_axi_wdata;
            wstrb_q <= axi.s_axi_wstrb;
         end
         if (wr_fire) begin
            bvalid <= 1'b1;
            bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
         end
         if (bvalid && axi.s_axi_bready) begin
            bvalid  <= 1'b0;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rvalid <= 1'b0;
         rdata  <= '0;
         rresp  <= RESP_OKAY;
      end else if (axi.s_axi_arvalid && !rvalid) begin
         rvalid <= 1'b1;
         rdata  <= rd_word;
         rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (rvalid && axi.s_axi_rready) begin
         rvalid <= 1'b0;
      end
   end

   assign axi.s_axi_awready = !aw_held && !bvalid;
   assign axi.s_axi_wready  = !w_held && !bvalid;
   assign axi.s_axi_bvalid  = bvalid;
   assign axi.s_axi_bresp   = bresp;
   assign axi.s_axi_arready = !rvalid;
   assign axi.s_axi_rvalid  = rvalid;
   assign axi.s_axi_rdata   = rdata;
   assign axi.s_axi_rresp   = rresp;
   assign crf_ac_upstart    = upstart;
   assign crf_ac_busy       = busy;

   logic unused_bits;
   assign unused_bits = &{1'b0, axi.s_axi_awprot, axi.s_axi_arprot, wdata_q[31:2], wstrb_q[3:1]};
endmodule

// File: tb/tb_crf_multi_ch.sv
// tb/tb_crf_multi_ch.sv - directed self-checking bench for crf_multi_ch
module tb_crf_multi_ch;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] upstart, busy, ac_done;
   logic       irq;
   int         checks = 0;
   int         errors = 0;
   int         ch0_pulses = 0;

   always #5 clk = ~clk;

   crf_multi_ch_if #(.ADDR_WIDTH(12)) axi ();

   crf_multi_ch #(.N_CH(4), .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(12), .CNT_WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .axi(axi), .crf_ac_upstart(upstart), .crf_ac_busy(busy),
      .ac_crf_done(ac_done), .interrupt_updone(irq)
   );

   always @(negedge clk) if (upstart[0]) ch0_pulses++;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic axi_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] resp, output logic [3:0] up_b);
      logic aw_acc, w_acc;
      int   n;
      axi.s_axi_awaddr = addr; axi.s_axi_wdata = data; axi.s_axi_wstrb = strb;
      axi.s_axi_awvalid = 1'b1; axi.s_axi_wvalid = 1'b1;
      n = 0;
      while ((axi.s_axi_awvalid || axi.s_axi_wvalid) && n < 20) begin
         aw_acc = axi.s_axi_awvalid && axi.s_axi_awready;
         w_acc  = axi.s_axi_wvalid && axi.s_axi_wready;
         step();
         if (aw_acc) axi.s_axi_awvalid = 1'b0;
         if (w_acc) axi.s_axi_wvalid = 1'b0;
         n++;
      end
      axi.s_axi_awvalid = 1'b0; axi.s_axi_wvalid = 1'b0;
      n = 0;
      while (!axi.s_axi_bvalid && n < 20) begin step(); n++; end
      checks++;
      if (axi.s_axi_bvalid !== 1'b1) begin
         errors++;
         $display("FAIL write_bvalid addr=%h got %b required 1", addr, axi.s_axi_bvalid);
      end
      resp = axi.s_axi_bresp;
      up_b = upstart;
      axi.s_axi_bready = 1'b1;
      step();
      axi.s_axi_bready = 1'b0;
   endtask

   task automatic axi_read(input logic [11:0] addr, output logic [31:0] data, output logic [1:0] resp);
      int n;
      axi.s_axi_araddr = addr; axi.s_axi_arvalid = 1'b1;
      n = 0;
      while (!axi.s_axi_arready && n < 20) begin step(); n++; end
      step();
      axi.s_axi_arvalid = 1'b0;
      n = 0;
      while (!axi.s_axi_rvalid && n < 20) begin step(); n++; end
      checks++;
      if (axi.s_axi_rvalid !== 1'b1) begin
         errors++;
         $display("FAIL read_rvalid addr=%h got %b required 1", addr, axi.s_axi_rvalid);
      end
      data = axi.s_axi_rdata;
      resp = axi.s_axi_rresp;
      axi.s_axi_rready = 1'b1;
      step();
      axi.s_axi_rready = 1'b0;
   endtask

   // Write whose register update lands on the same edge as a done pulse on channel ch.
   task automatic write_with_done(input logic [11:0] addr, input logic [31:0] data, input int ch,
                                  output logic [3:0] up_b);
      axi.s_axi_awaddr = addr; axi.s_axi_wdata = data; axi.s_axi_wstrb = 4'hF;
      axi.s_axi_awvalid = 1'b1; axi.s_axi_wvalid = 1'b1;
      step();
      axi.s_axi_awvalid = 1'b0; axi.s_axi_wvalid = 1'b0;
      ac_done[ch] = 1'b1;
      step();
      ac_done = '0;
      checks++;
      if (axi.s_axi_bvalid !== 1'b1) begin
         errors++;
         $display("FAIL wwd_bvalid addr=%h got %b required 1", addr, axi.s_axi_bvalid);
      end
      up_b = upstart;
      axi.s_axi_bready = 1'b1;
      step();
      axi.s_axi_bready = 1'b0;
   endtask

   task automatic pulse_done(input int ch);
      ac_done[ch] = 1'b1;
      step();
      ac_done = '0;
   endtask

   task automatic expect32(input string name, input logic [31:0] got, input logic [31:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s got %h required %h", name, got, req);
      end
   endtask

   task automatic test_reset();
      logic [31:0] d; logic [1:0] r;
      rst_n = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      step();
      checks++;
      if ({axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_arready} !== 3'b111) begin
         errors++; $display("FAIL reset_ready got %b required 111",
                            {axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_arready});
      end
      checks++;
      if ({axi.s_axi_bvalid, axi.s_axi_rvalid, irq, upstart, busy} !== 11'd0) begin
         errors++; $display("FAIL reset_outputs got %b required 0",
                            {axi.s_axi_bvalid, axi.s_axi_rvalid, irq, upstart, busy});
      end
      axi_read(12'h004, d, r);
      expect32("reset_status", d, 32'h0);
      expect32("reset_status_resp", 32'(r), 32'h0);
   endtask

   task automatic test_start_done();
      logic [31:0] d; logic [1:0] r; logic [3:0] u;
      axi_write(12'h010, 32'h3, 4'hF, r, u);
      expect32("ch1_start_resp", 32'(r), 32'h0);
      expect32("ch1_upstart", 32'(u), 32'h2);
      expect32("ch1_upstart_after", 32'(upstart), 32'h0);
      axi_read(12'h014, d, r);
      expect32("ch1_status_busy", d, 32'h1);
      pulse_done(1);
      expect32("ch1_irq_not_yet", 32'(irq), 32'h0);
      step();
      expect32("ch1_irq_set", 32'(irq), 32'h1);
      axi_read(12'h014, d, r);
      expect32("ch1_status_done", d, 32'h2);
      axi_read(12'h018, d, r);
      expect32("ch1_frmcnt", d, 32'h1);
      axi_read(12'h100, d, r);
      expect32("irqstat", d, 32'h2);
      axi_write(12'h014, 32'h2, 4'hF, r, u);
      expect32("ch1_irq_cleared", 32'(irq), 32'h0);
      axi_read(12'h014, d, r);
      expect32("ch1_status_cleared", d, 32'h0);
   endtask

   task automatic test_back_to_back();
      logic [31:0] d; logic [1:0] r; logic [3:0] u; int base;
      base = ch0_pulses;
      axi_write(12'h000, 32'h1, 4'hF, r, u);
      expect32("ch0_first_upstart", 32'(u), 32'h1);
      axi_write(12'h000, 32'h1, 4'hF, r, u);
      expect32("ch0_second_upstart", 32'(u), 32'h0);
      expect32("ch0_second_resp", 32'(r), 32'h0);
      expect32("ch0_pulse_count", 32'(ch0_pulses - base), 32'h1);
      expect32("ch0_busy", 32'(busy), 32'h1);
      write_with_done(12'h004, 32'h2, 0, u);
      axi_read(12'h004, d, r);
      expect32("w1c_vs_done", d, 32'h2);
      axi_write(12'h000, 32'h1, 4'hF, r, u);
      expect32("ch0_restart_upstart", 32'(u), 32'h1);
      write_with_done(12'h000, 32'h1, 0, u);
      expect32("start_vs_done_upstart", 32'(u), 32'h0);
      expect32("start_vs_done_busy", 32'(busy), 32'h0);
      axi_read(12'h008, d, r);
      expect32("ch0_frmcnt", d, 32'h2);
   endtask

   task automatic test_w_before_aw();
      logic [31:0] d; logic [1:0] r; int hb, ar_bad;
      axi.s_axi_wdata = 32'h2; axi.s_axi_wstrb = 4'hF; axi.s_axi_wvalid = 1'b1;
      step();
      axi.s_axi_wvalid = 1'b0;
      expect32("w_only_wready_low", 32'(axi.s_axi_wready), 32'h0);
      expect32("w_only_no_bvalid", 32'(axi.s_axi_bvalid), 32'h0);
      step(); step();
      axi.s_axi_awaddr = 12'h030; axi.s_axi_awvalid = 1'b1;
      expect32("aw_ready_late", 32'(axi.s_axi_awready), 32'h1);
      step();
      axi.s_axi_awvalid = 1'b0;
      step();
      axi.s_axi_awaddr = 12'h034; axi.s_axi_awvalid = 1'b1;
      hb = 0; ar_bad = 0;
      for (int k = 0; k < 5; k++) begin
         if (axi.s_axi_bvalid) hb++;
         if (axi.s_axi_awready) ar_bad++;
         step();
      end
      expect32("bvalid_held_cycles", 32'(hb), 32'd5);
      expect32("aw_blocked_cycles", 32'(ar_bad), 32'd0);
      expect32("held_bresp", 32'(axi.s_axi_bresp), 32'h0);
      axi.s_axi_bready = 1'b1;
      step();
      axi.s_axi_bready = 1'b0; axi.s_axi_awvalid = 1'b0;
      expect32("bvalid_released", 32'(axi.s_axi_bvalid), 32'h0);
      expect32("aw_ready_released", 32'(axi.s_axi_awready), 32'h1);
      axi_read(12'h030, d, r);
      expect32("ch3_ctrl", d, 32'h2);
   endtask

   task automatic test_slverr();
      logic [31:0] d; logic [1:0] r; logic [3:0] u;
      axi_read(12'h040, d, r);
      expect32("rd_040_resp", 32'(r), 32'h2);
      expect32("rd_040_data", d, 32'h0);
      axi_write(12'h200, 32'h3, 4'hF, r, u);
      expect32("wr_200_resp", 32'(r), 32'h2);
      axi_write(12'h040, 32'h3, 4'hF, r, u);
      expect32("wr_040_resp", 32'(r), 32'h2);
      expect32("wr_040_upstart", 32'(u), 32'h0);
      axi_read(12'h010, d, r);
      expect32("ch1_ctrl_unchanged", d, 32'h2);
      axi_read(12'h00C, d, r);
      expect32("reserved_data", d, 32'h0);
      expect32("reserved_resp", 32'(r), 32'h0);
      axi_write(12'h020, 32'h1, 4'h0, r, u);
      expect32("strb0_resp", 32'(r), 32'h0);
      expect32("strb0_upstart", 32'(u), 32'h0);
      expect32("strb0_busy", 32'(busy), 32'h0);
   endtask

   task automatic test_wrap();
      logic [31:0] d; logic [1:0] r; logic [3:0] u;
      for (int k = 0; k < 15; k++) begin
         axi_write(12'h020, 32'h1, 4'hF, r, u);
         pulse_done(2);
      end
      axi_read(12'h028, d, r);
      expect32("ch2_frmcnt_15", d, 32'hF);
      axi_write(12'h020, 32'h1, 4'hF, r, u);
      pulse_done(2);
      axi_read(12'h028, d, r);
      expect32("ch2_frmcnt_wrap", d, 32'h0);
      axi_read(12'h024, d, r);
      expect32("ch2_status_done", d, 32'h2);
      pulse_done(2);
      axi_read(12'h028, d, r);
      expect32("ch2_done_idle_ignored", d, 32'h0);
   endtask

   task automatic test_reset_mid();
      logic [31:0] d; logic [1:0] r;
      axi.s_axi_awaddr = 12'h020; axi.s_axi_wdata = 32'h1; axi.s_axi_wstrb = 4'hF;
      axi.s_axi_awvalid = 1'b1; axi.s_axi_wvalid = 1'b1;
      step();
      axi.s_axi_awvalid = 1'b0; axi.s_axi_wvalid = 1'b0;
      step();
      expect32("pre_rst_bvalid", 32'(axi.s_axi_bvalid), 32'h1);
      expect32("pre_rst_busy", 32'(busy), 32'h4);
      rst_n = 1'b0;
      step();
      expect32("rst_bvalid", 32'(axi.s_axi_bvalid), 32'h0);
      expect32("rst_busy", 32'(busy), 32'h0);
      expect32("rst_upstart", 32'(upstart), 32'h0);
      rst_n = 1'b1;
      step();
      axi_read(12'h018, d, r);
      expect32("rst_ch1_frmcnt", d, 32'h0);
      axi_read(12'h010, d, r);
      expect32("rst_ch1_ctrl", d, 32'h0);
   endtask

   initial begin
      ac_done = '0;
      axi.s_axi_awvalid = 1'b0; axi.s_axi_awaddr = '0; axi.s_axi_awprot = '0;
      axi.s_axi_wvalid = 1'b0; axi.s_axi_wdata = '0; axi.s_axi_wstrb = '0;
      axi.s_axi_bready = 1'b0;
      axi.s_axi_arvalid = 1'b0; axi.s_axi_araddr = '0; axi.s_axi_arprot = '0;
      axi.s_axi_rready = 1'b0;
      test_reset();
      test_start_done();
      test_back_to_back();
      test_w_before_aw();
      test_slverr();
      test_wrap();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
